enq_qlist_ctrl: RTL and testbench



---
 rtl/enq_qlist_ctrl_pkg.sv | 18 +
 rtl/enq_qlist_ctrl_if.sv | 41 ++++
 rtl/enq_qlist_ctrl_tbl.sv | 68 ++++++
 rtl/enq_qlist_ctrl.sv | 101 ++++++++++
 tb/tb_enq_qlist_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/enq_qlist_ctrl_pkg.sv
// Shared types for the per-queue enqueue linked-list controller.
// Holds the descriptor layout popped from the enqueue FIFO and the FSM state encoding.
package enq_qlist_ctrl_pkg;

  localparam int DESC_QID_NBITS = 4;
  localparam int DESC_PTR_NBITS = 10;

  typedef struct packed {
    logic [DESC_QID_NBITS-1:0] qid;
    logic [DESC_PTR_NBITS-1:0] buf_ptr;
  } enq_pkt_desc_type;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EVAL = 1'b1
  } enq_qlist_state_e;

endpackage

// File: rtl/enq_qlist_ctrl_if.sv
// Bundle of descriptor-FIFO, link-memory, head, dequeue-decrement and status signals.
// The slave modport is the controller's view; master is the environment's view.
interface enq_qlist_ctrl_if
  import enq_qlist_ctrl_pkg::*;
#(
  parameter int NUM_Q_NBITS   = 4,
  parameter int BUF_PTR_NBITS = 10
) ();

  logic                         desc_empty;
  enq_pkt_desc_type             desc;
  logic                         desc_rd;
  logic                         link_rdy;
  logic                         link_wr;
  logic [BUF_PTR_NBITS-1:0]     link_waddr;
  logic [BUF_PTR_NBITS-1:0]     link_wdata;
  logic                         head_wr;
  logic [NUM_Q_NBITS-1:0]       head_qid;
  logic [BUF_PTR_NBITS-1:0]     head_wdata;
  logic                         deq_dec;
  logic [NUM_Q_NBITS-1:0]       deq_qid;
  logic                         enq_done;
  logic [NUM_Q_NBITS-1:0]       enq_qid;
  logic                         drop_vld;
  logic [BUF_PTR_NBITS-1:0]     drop_buf_ptr;
  logic [(1<<NUM_Q_NBITS)-1:0]  q_nonempty;
  logic [15:0]                  drop_cnt;

  modport slave (
    input  desc_empty, desc, link_rdy, deq_dec, deq_qid,
    output desc_rd, link_wr, link_waddr, link_wdata, head_wr, head_qid, head_wdata,
           enq_done, enq_qid, drop_vld, drop_buf_ptr, q_nonempty, drop_cnt
  );

  modport master (
    output desc_empty, desc, link_rdy, deq_dec, deq_qid,
    input  desc_rd, link_wr, link_waddr, link_wdata, head_wr, head_qid, head_wdata,
           enq_done, enq_qid, drop_vld, drop_buf_ptr, q_nonempty, drop_cnt
  );

endinterface

// File: rtl/enq_qlist_ctrl_tbl.sv
// Per-queue tail pointer and occupancy tables: one read port, one commit port, one decrement port.
// A commit to the same queue as a decrement wins, since the commit count already folds the decrement in.
module enq_qlist_tbl
  import enq_qlist_ctrl_pkg::*;
#(
  parameter int NUM_Q_NBITS   = 4,
  parameter int BUF_PTR_NBITS = 10,
  parameter int QCNT_NBITS    = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_Q_NBITS-1:0]      i_rd_qid,
  output logic [BUF_PTR_NBITS-1:0]    o_rd_tail,
  output logic [QCNT_NBITS-1:0]       o_rd_cnt,
  input  logic                        i_cmt,
  input  logic [NUM_Q_NBITS-1:0]      i_cmt_qid,
  input  logic [BUF_PTR_NBITS-1:0]    i_cmt_ptr,
  input  logic [QCNT_NBITS-1:0]       i_cmt_cnt,
  input  logic                        i_dec,
  input  logic [NUM_Q_NBITS-1:0]      i_dec_qid,
  output logic [(1<<NUM_Q_NBITS)-1:0] o_q_nonempty
);

  localparam int NUM_Q = 1 << NUM_Q_NBITS;

  logic [BUF_PTR_NBITS-1:0] r_tail [NUM_Q];
  logic [QCNT_NBITS-1:0]    r_cnt  [NUM_Q];
  logic [QCNT_NBITS-1:0]    w_cnt_nxt [NUM_Q];
  logic [NUM_Q-1:0]         r_q_nonempty;

  always_comb begin
    for (int q = 0; q < NUM_Q; q++) begin
      w_cnt_nxt[q] = r_cnt[q];
      if (i_dec && (i_dec_qid == NUM_Q_NBITS'(q)) && (r_cnt[q] != '0))
        w_cnt_nxt[q] = r_cnt[q] - QCNT_NBITS'(1);
      if (i_cmt && (i_cmt_qid == NUM_Q_NBITS'(q)))
        w_cnt_nxt[q] = i_cmt_cnt;
    end
  end

  // Non-empty flags track the next count so they move on the same edge as the table.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int q = 0; q < NUM_Q; q++) r_cnt[q] <= '0;
      r_q_nonempty <= '0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        r_cnt[q]        <= w_cnt_nxt[q];
        r_q_nonempty[q] <= (w_cnt_nxt[q] != '0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_cmt) r_tail[i_cmt_qid] <= i_cmt_ptr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n)
      assert (!(i_dec && (r_cnt[i_dec_qid] == '0)))
        else $error("ERROR: deq_dec on empty queue %0d", i_dec_qid);
  end

  assign o_rd_tail    = r_tail[i_rd_qid];
  assign o_rd_cnt     = r_cnt[i_rd_qid];
  assign o_q_nonempty = r_q_nonempty;

endmodule

// File: rtl/enq_qlist_ctrl.sv
// Pops enqueue descriptors and appends each buffer to its queue's linked list, or drops it at the depth limit.
// One descriptor per two cycles; link_rdy low holds the controller in EVAL with all strobes stable.
module enq_qlist_ctrl
  import enq_qlist_ctrl_pkg::*;
#(
  parameter int NUM_Q_NBITS   = 4,
  parameter int BUF_PTR_NBITS = 10,
  parameter int QCNT_NBITS    = 8,
  parameter int Q_MAX         = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  enq_qlist_ctrl_if.slave  io_qif
);

  localparam logic [QCNT_NBITS-1:0] QMAX_C = QCNT_NBITS'(Q_MAX);

  enq_qlist_state_e          r_state;
  logic [NUM_Q_NBITS-1:0]    r_cur_qid;
  logic [BUF_PTR_NBITS-1:0]  r_cur_ptr;
  logic [15:0]               r_drop_cnt;

  logic                      w_in_eval;
  logic [BUF_PTR_NBITS-1:0]  w_tail;
  logic [QCNT_NBITS-1:0]     w_cnt;
  logic                      w_dec_hit;
  logic [QCNT_NBITS-1:0]     w_eff;
  logic                      w_full;
  logic                      w_first;
  logic                      w_drop;
  logic                      w_commit;
  logic                      w_pop;

  assign w_in_eval = (r_state == EVAL);
  assign w_pop     = (r_state == IDLE) && !io_qif.desc_empty;

  // A decrement landing during EVAL on the same queue frees a slot for this descriptor.
  assign w_dec_hit = io_qif.deq_dec && (io_qif.deq_qid == r_cur_qid) && (w_cnt != '0);
  assign w_eff     = w_cnt - QCNT_NBITS'(w_dec_hit);
  assign w_full    = (w_eff >= QMAX_C);
  assign w_first   = (w_eff == '0);
  assign w_drop    = w_in_eval && w_full;
  assign w_commit  = w_in_eval && !w_full && (w_first || io_qif.link_rdy);

  enq_qlist_tbl #(
    .NUM_Q_NBITS   (NUM_Q_NBITS),
    .BUF_PTR_NBITS (BUF_PTR_NBITS),
    .QCNT_NBITS    (QCNT_NBITS)
  ) u_tbl (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rd_qid     (r_cur_qid),
    .o_rd_tail    (w_tail),
    .o_rd_cnt     (w_cnt),
    .i_cmt        (w_commit),
    .i_cmt_qid    (r_cur_qid),
    .i_cmt_ptr    (r_cur_ptr),
    .i_cmt_cnt    (w_eff + QCNT_NBITS'(1)),
    .i_dec        (io_qif.deq_dec),
    .i_dec_qid    (io_qif.deq_qid),
    .o_q_nonempty (io_qif.q_nonempty)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cur_qid  <= '0;
      r_cur_ptr  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_cur_qid <= io_qif.desc.qid;
            r_cur_ptr <= io_qif.desc.buf_ptr;
            r_state   <= EVAL;
          end
        end
        EVAL: begin
          if (w_drop || w_commit) r_state <= IDLE;
          if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_qif.desc_rd      = w_pop;
  assign io_qif.link_wr      = w_in_eval && !w_full && !w_first;
  assign io_qif.link_waddr   = w_tail;
  assign io_qif.link_wdata   = r_cur_ptr;
  assign io_qif.head_wr      = w_in_eval && !w_full && w_first;
  assign io_qif.head_qid     = r_cur_qid;
  assign io_qif.head_wdata   = r_cur_ptr;
  assign io_qif.enq_done     = w_commit;
  assign io_qif.enq_qid      = r_cur_qid;
  assign io_qif.drop_vld     = w_drop;
  assign io_qif.drop_buf_ptr = r_cur_ptr;
  assign io_qif.drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_enq_qlist_ctrl.sv
// Scoreboard bench for enq_qlist_ctrl with a small depth limit so drops are reachable.
module tb_enq_qlist_ctrl;
  import enq_qlist_ctrl_pkg::*;

  localparam int NQB  = 4;
  localparam int PB   = 10;
  localparam int CB   = 8;
  localparam int QMAX = 2;
  localparam int NQ   = 1 << NQB;

  typedef struct {
    int kind;   // 0 head, 1 link, 2 drop
    int qid;
    int ptr;
    int waddr;
    int cnt;
    int hold;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enq_qlist_ctrl_if #(.NUM_Q_NBITS(NQB), .BUF_PTR_NBITS(PB)) qif ();

  enq_qlist_ctrl #(
    .NUM_Q_NBITS(NQB), .BUF_PTR_NBITS(PB), .QCNT_NBITS(CB), .Q_MAX(QMAX)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_qif  (qif)
  );

  int n_vec = 0;
  int n_miss = 0;

  exp_t             sb[$];
  enq_pkt_desc_type fifo[$];
  int p_cnt [NQ];
  int p_tail[NQ];
  int m_cnt [NQ];
  int exp_drops = 0;
  int cyc = 0, last_rd = 0, n_rd = 0, link_cyc = 0;
  bit have_last = 0, chk_gap = 0, pop_pend = 0, mon_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    qif.desc_empty = (fifo.size() == 0);
    qif.desc = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic mon();
    int tmp[NQ];
    logic [NQ-1:0] exp_ne;
    exp_t e;
    int obs_kind;
    cyc++;
    for (int q = 0; q < NQ; q++) exp_ne[q] = (m_cnt[q] != 0);
    chk("q_nonempty", qif.q_nonempty, exp_ne);
    if (qif.desc_rd) begin
      n_rd++;
      if (chk_gap && have_last) chk("rd_gap", cyc - last_rd, 2);
      last_rd = cyc; have_last = 1; pop_pend = 1;
    end
    tmp = m_cnt;
    if (qif.deq_dec && tmp[qif.deq_qid] != 0) tmp[qif.deq_qid]--;
    if (qif.head_wr && !qif.enq_done) chk("head_wr_wo_done", 1, 0);
    if (qif.drop_vld || qif.enq_done) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        obs_kind = qif.drop_vld ? 2 : (qif.head_wr ? 0 : 1);
        chk("kind", obs_kind, e.kind);
        if (e.kind == 2) begin
          chk("drop_ptr", qif.drop_buf_ptr, e.ptr);
          chk("drop_no_done", qif.enq_done, 0);
        end else begin
          chk("enq_qid", qif.enq_qid, e.qid);
          if (e.kind == 0) begin
            chk("head_qid", qif.head_qid, e.qid);
            chk("head_wdata", qif.head_wdata, e.ptr);
            chk("head_no_link", qif.link_wr, 0);
          end else begin
            chk("link_waddr", qif.link_waddr, e.waddr);
            chk("link_wdata", qif.link_wdata, e.ptr);
            chk("link_cycles", link_cyc + 1, e.hold);
          end
          tmp[e.qid]++;
          chk("count", tmp[e.qid], e.cnt);
        end
      end
      link_cyc = 0;
    end else if (qif.link_wr) begin
      link_cyc++;
      if (sb.size() != 0) begin
        chk("stall_waddr", qif.link_waddr, sb[0].waddr);
        chk("stall_wdata", qif.link_wdata, sb[0].ptr);
      end
    end
    m_cnt = tmp;
  endtask

  task automatic tick();
    @(negedge clk);
    if (mon_on) mon();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      if (fifo.size() != 0) void'(fifo.pop_front());
      pop_pend = 0;
    end
    drive_fifo();
  endtask

  task automatic push(input int q, input int ptr, input bit dec, input int hold);
    exp_t e;
    int eff;
    eff = p_cnt[q] - ((dec && p_cnt[q] > 0) ? 1 : 0);
    e.qid = q; e.ptr = ptr; e.hold = hold; e.waddr = p_tail[q]; e.cnt = 0;
    if (eff >= QMAX) begin
      e.kind = 2; p_cnt[q] = eff; exp_drops++;
    end else begin
      e.kind = (eff == 0) ? 0 : 1;
      p_tail[q] = ptr; p_cnt[q] = eff + 1; e.cnt = eff + 1;
    end
    sb.push_back(e);
    fifo.push_back('{qid: NQB'(q), buf_ptr: PB'(ptr)});
    drive_fifo();
  endtask

  task automatic wait_rd(input int budget);
    int n0 = n_rd;
    while (n_rd == n0 && budget > 0) begin tick(); budget--; end
    if (n_rd == n0) chk("rd_timeout", 0, 1);
  endtask

  task automatic run_idle(input int budget);
    while ((fifo.size() != 0 || sb.size() != 0) && budget > 0) begin tick(); budget--; end
    if (fifo.size() != 0 || sb.size() != 0) chk("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic dec_q(input int q);
    qif.deq_dec = 1'b1; qif.deq_qid = NQB'(q);
    if (p_cnt[q] > 0) p_cnt[q]--;
    tick();
    qif.deq_dec = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int q = 0; q < NQ; q++) begin p_cnt[q] = 0; p_tail[q] = 0; m_cnt[q] = 0; end
    qif.link_rdy = 1'b1; qif.deq_dec = 1'b0; qif.deq_qid = '0;
    drive_fifo();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_rd", qif.desc_rd, 0);
    chk("rst_link_wr", qif.link_wr, 0);
    chk("rst_head_wr", qif.head_wr, 0);
    chk("rst_enq_done", qif.enq_done, 0);
    chk("rst_drop_vld", qif.drop_vld, 0);
    chk("rst_q_nonempty", qif.q_nonempty, 0);
    chk("rst_drop_cnt", qif.drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1;

    // First packet into an empty queue loads the head.
    push(3, 'h010, 0, 1);
    run_idle(20);

    // Second packet to queue 3 with the link memory stalled for three cycles.
    qif.link_rdy = 1'b0;
    n0 = n_rd;
    push(3, 'h011, 0, 4);
    wait_rd(20);
    repeat (3) tick();
    qif.link_rdy = 1'b1;
    run_idle(20);
    chk("stall_rd_count", n_rd - n0, 1);

    // Queue 3 at its limit: the third packet is dropped.
    push(3, 'h012, 0, 1);
    run_idle(20);
    chk("drop_cnt_1", qif.drop_cnt, exp_drops);

    // Drain and refill queue 5 in the same cycle.
    push(5, 'h01F, 0, 1);
    run_idle(20);
    push(5, 'h020, 1, 1);
    wait_rd(20);
    qif.deq_dec = 1'b1; qif.deq_qid = 4'd5;
    tick();
    qif.deq_dec = 1'b0;
    run_idle(20);

    // Back-to-back FIFO across four queues.
    chk_gap = 1; have_last = 0;
    for (int i = 0; i < 8; i++) begin
      int qs[4] = '{0, 1, 2, 4};
      push(qs[i % 4], 'h100 + i, 0, 1);
    end
    run_idle(100);
    chk_gap = 0;
    chk("drop_cnt_b2b", qif.drop_cnt, exp_drops);

    // Queue 0 now holds two packets, so one more must drop.
    push(0, 'h0AA, 0, 1);
    run_idle(20);
    chk("drop_cnt_2", qif.drop_cnt, exp_drops);

    // Plain decrements empty queue 4.
    dec_q(4);
    dec_q(4);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
